rs232_tx_serializer: RTL and testbench

Byte-to-serial UART transmitter, 8N1 framing, LSB first. Sits directly downstream of the manager TX FSM and consumes its RS_DATAIN / RS_TRG_WRITE pair. Drives the board RS232 TX pin. Has a one-deep holding register so the manager can queue one byte while a frame is in flight.

---
 rtl/rs232_pkg.sv | 14 +
 rtl/rs232_tx_serializer_if.sv | 19 +
 rtl/rs232_baud_gen.sv | 26 ++
 rtl/rs232_tx_serializer.sv | 127 ++++++++++++
 tb/tb_rs232_tx_serializer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared RS232 state encoding and framing constants
package rs232_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEFAULT_BAUD_DIV = 434;
    localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/rs232_tx_serializer_if.sv
// rtl/rs232_tx_serializer_if.sv - byte write strobe in, serial line and status out
interface rs232_tx_serializer_if;
    logic [7:0] RS_DATAIN;
    logic       RS_TRG_WRITE;
    logic       RS_TX;
    logic       RS_BUSY;
    logic       RS_DONE;
    logic       RS_OVERRUN;

    modport master (
        output RS_DATAIN, RS_TRG_WRITE,
        input  RS_TX, RS_BUSY, RS_DONE, RS_OVERRUN
    );

    modport slave (
        input  RS_DATAIN, RS_TRG_WRITE,
        output RS_TX, RS_BUSY, RS_DONE, RS_OVERRUN
    );
endinterface

// File: rtl/rs232_baud_gen.sv
// rtl/rs232_baud_gen.sv - bit-period counter producing a tick in the last clock of each bit
module rs232_baud_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_end
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    assign bit_end = run && (cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/rs232_tx_serializer.sv
// rtl/rs232_tx_serializer.sv - 8N1 LSB-first UART transmitter with a one-deep holding register
module rs232_tx_serializer
    import rs232_pkg::*;
#(
    parameter int   BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                 CLK_50MHZ,
    input  logic                 RST,
    rs232_tx_serializer_if.slave bus
);
    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [7:0] hold, hold_n;
    logic       hold_full, hold_full_n;
    logic [2:0] idx, idx_n;
    logic       tx, tx_n;
    logic       busy;
    logic       overrun, overrun_n;
    logic       bit_end;
    logic       start_frame;

    assign start_frame = (state == IDLE) && bus.RS_TRG_WRITE;

    rs232_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk     (CLK_50MHZ),
        .rst     (RST),
        .clear   (start_frame),
        .run     (state != IDLE),
        .bit_end (bit_end)
    );

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        idx_n       = idx;
        overrun_n   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.RS_TRG_WRITE) begin
                    shift_n = bus.RS_DATAIN;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (hold_full) begin
                        shift_n     = hold;
                        hold_full_n = 1'b0;
                        state_n     = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase

        // In the STOP bit_end cycle the holding slot is being vacated, so a write never overruns there
        if (bus.RS_TRG_WRITE && (state != IDLE)) begin
            if ((state == STOP) && bit_end) begin
                if (hold_full) begin
                    hold_n      = bus.RS_DATAIN;
                    hold_full_n = 1'b1;
                end else begin
                    shift_n = bus.RS_DATAIN;
                    state_n = START;
                end
            end else if (!hold_full) begin
                hold_n      = bus.RS_DATAIN;
                hold_full_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end

        case (state_n)
            START:   tx_n = ~IDLE_LEVEL;
            DATA:    tx_n = shift_n[0];
            default: tx_n = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state     <= IDLE;
            shift     <= 8'd0;
            hold      <= 8'd0;
            hold_full <= 1'b0;
            idx       <= 3'd0;
            tx        <= IDLE_LEVEL;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            idx       <= idx_n;
            tx        <= tx_n;
            busy      <= (state_n != IDLE) || hold_full_n;
            overrun   <= overrun_n;
        end
    end

    assign bus.RS_TX      = tx;
    assign bus.RS_BUSY    = busy;
    assign bus.RS_DONE    = (state == STOP) && bit_end;
    assign bus.RS_OVERRUN = overrun;
endmodule

// File: tb/tb_rs232_tx_serializer.sv
// tb/tb_rs232_tx_serializer.sv - directed self-checking bench for the RS232 transmitter
module tb_rs232_tx_serializer;
    import rs232_pkg::*;

    localparam int BD = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rs232_tx_serializer_if bus();
    rs232_tx_serializer_if bus_d();

    rs232_tx_serializer #(.BAUD_DIV(BD)) dut (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .bus       (bus)
    );

    rs232_tx_serializer dut_d (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .bus       (bus_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level at bit position pos (0 = start, 1..8 = data LSB first, 9 = stop)
    function automatic logic fbit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        return 1'b1;
    endfunction

    // Expected line for a frame whose start bit begins at cycle s, or idle outside it
    function automatic logic txf(input logic [7:0] b, input int s, input int c, input int bd);
        if (c >= s && c < s + FRAME_BITS * bd) return fbit(b, (c - s) / bd);
        return 1'b1;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.RS_TRG_WRITE = 1'b0;
        bus.RS_DATAIN = 8'h00;
        bus_d.RS_TRG_WRITE = 1'b0;
        bus_d.RS_DATAIN = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.RS_TX !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", bus.RS_TX); end
        checks++;
        if (bus.RS_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.RS_BUSY); end
        checks++;
        if (bus.RS_DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.RS_DONE); end
        checks++;
        if (bus.RS_OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.RS_OVERRUN); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [3:0] got, exp;
        for (int c = 0; c <= 44; c++) begin
            bus.RS_TRG_WRITE = (c == 0);
            bus.RS_DATAIN = (c == 0) ? 8'h55 : 8'hxx;
            @(negedge clk);
            exp = {txf(8'h55, 1, c, BD), (c >= 1 && c <= 40), (c == 40), 1'b0};
            got = {bus.RS_TX, bus.RS_BUSY, bus.RS_DONE, bus.RS_OVERRUN};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_55 c=%0d {tx,busy,done,ovr} got=%b exp=%b", c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] got, exp;
        for (int c = 0; c <= 84; c++) begin
            bus.RS_TRG_WRITE = (c == 0 || c == 10);
            bus.RS_DATAIN = (c == 0) ? 8'hA5 : (c == 10) ? 8'h3C : 8'hxx;
            @(negedge clk);
            exp = {txf(8'hA5, 1, c, BD) & txf(8'h3C, 41, c, BD),
                   (c >= 1 && c <= 80), (c == 40 || c == 80), 1'b0};
            got = {bus.RS_TX, bus.RS_BUSY, bus.RS_DONE, bus.RS_OVERRUN};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back c=%0d {tx,busy,done,ovr} got=%b exp=%b", c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overrun;
        logic [3:0] got, exp;
        for (int c = 0; c <= 90; c++) begin
            bus.RS_TRG_WRITE = (c == 0 || c == 5 || c == 6);
            bus.RS_DATAIN = (c == 0) ? 8'h12 : (c == 5) ? 8'h34 : (c == 6) ? 8'h56 : 8'hxx;
            @(negedge clk);
            exp = {txf(8'h12, 1, c, BD) & txf(8'h34, 41, c, BD),
                   (c >= 1 && c <= 80), (c == 40 || c == 80), (c == 7)};
            got = {bus.RS_TX, bus.RS_BUSY, bus.RS_DONE, bus.RS_OVERRUN};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL overrun c=%0d {tx,busy,done,ovr} got=%b exp=%b", c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [3:0] got, exp;
        logic       etx;
        for (int c = 0; c <= 94; c++) begin
            bus.RS_TRG_WRITE = (c == 0 || c == 50);
            bus.RS_DATAIN = (c == 0) ? 8'hFF : (c == 50) ? 8'h00 : 8'hxx;
            rst = (c == 15);
            @(negedge clk);
            etx = (c <= 15) ? txf(8'hFF, 1, c, BD) : txf(8'h00, 51, c, BD);
            exp = {etx, ((c >= 1 && c <= 15) || (c >= 51 && c <= 90)), (c == 90), 1'b0};
            got = {bus.RS_TX, bus.RS_BUSY, bus.RS_DONE, bus.RS_OVERRUN};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_frame c=%0d {tx,busy,done,ovr} got=%b exp=%b", c, got, exp);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_write_at_stop_end;
        logic [3:0] got, exp;
        for (int c = 0; c <= 84; c++) begin
            bus.RS_TRG_WRITE = (c == 0 || c == 40);
            bus.RS_DATAIN = (c == 0) ? 8'h81 : (c == 40) ? 8'h42 : 8'hxx;
            @(negedge clk);
            exp = {txf(8'h81, 1, c, BD) & txf(8'h42, 41, c, BD),
                   (c >= 1 && c <= 80), (c == 40 || c == 80), 1'b0};
            got = {bus.RS_TX, bus.RS_BUSY, bus.RS_DONE, bus.RS_OVERRUN};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stop_end_write c=%0d {tx,busy,done,ovr} got=%b exp=%b", c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_default_baud;
        logic [3:0] got, exp;
        int         last;
        last = FRAME_BITS * DEFAULT_BAUD_DIV;
        for (int c = 0; c <= last + 4; c++) begin
            bus_d.RS_TRG_WRITE = (c == 0);
            bus_d.RS_DATAIN = (c == 0) ? 8'h0D : 8'hxx;
            @(negedge clk);
            exp = {txf(8'h0D, 1, c, DEFAULT_BAUD_DIV), (c >= 1 && c <= last), (c == last), 1'b0};
            got = {bus_d.RS_TX, bus_d.RS_BUSY, bus_d.RS_DONE, bus_d.RS_OVERRUN};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL default_baud c=%0d {tx,busy,done,ovr} got=%b exp=%b", c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_write_at_stop_end();
        test_default_baud();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
